// File: rtl/logic_unit_if.sv
// logic_unit_if: requester handshakes plus the shared logic-unit pins
interface logic_unit_if;
  logic       req0, a0, b0;
  logic [1:0] op0;
  logic       req1, a1, b1;
  logic [1:0] op1;
  logic       gnt0, gnt1, done0, done1, result, busy;
  logic       unit_a, unit_b, unit_chave1, unit_chave2, unit_y;
  modport master (
    output req0, a0, b0, op0, req1, a1, b1, op1, unit_y,
    input  gnt0, gnt1, done0, done1, result, busy, unit_a, unit_b, unit_chave1, unit_chave2
  );
  modport slave (
    input  req0, a0, b0, op0, req1, a1, b1, op1, unit_y,
    output gnt0, gnt1, done0, done1, result, busy, unit_a, unit_b, unit_chave1, unit_chave2
  );
endinterface

// File: rtl/logic_unit_scheduler.sv
// logic_unit_scheduler: round-robin sharing of one 1-bit AND/NAND/OR/NOR unit between two requesters
module logic_unit_scheduler #(
  parameter int SETTLE_CYCLES = 1
) (
  input logic        clk,
  input logic        reset,
  logic_unit_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);
  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] unit_q, unit_d;
  logic       last_q, last_d, win_q, win_d, result_q, result_d;
  logic       gnt0_q, gnt0_d, gnt1_q, gnt1_d, done0_q, done0_d, done1_q, done1_d;
  logic       acc, pick1;
  // arbitration and next-state: on a tie the requester that did not win last time goes next
  always_comb begin
    acc      = state_q == IDLE && (bus.req0 || bus.req1);
    pick1    = bus.req1 && (!bus.req0 || !last_q);
    state_d  = state_q;
    cnt_d    = cnt_q;
    unit_d   = unit_q;
    last_d   = last_q;
    win_d    = win_q;
    result_d = result_q;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    if (acc) begin
      state_d = WAIT;
      cnt_d   = CNT_INIT;
      last_d  = pick1;
      win_d   = pick1;
      gnt0_d  = !pick1;
      gnt1_d  = pick1;
      unit_d  = pick1 ? {bus.a1, bus.b1, bus.op1} : {bus.a0, bus.b0, bus.op0};
    end
    if (state_q == WAIT) begin
      state_d  = cnt_q == 4'd0 ? DONE : WAIT;
      cnt_d    = cnt_q == 4'd0 ? cnt_q : cnt_q - 4'd1;
      result_d = cnt_q == 4'd0 ? bus.unit_y : result_q;
    end
    if (state_q == DONE) begin
      state_d = IDLE;
      done0_d = !win_q;
      done1_d = win_q;
    end
    if (state_q == 2'd3) state_d = IDLE;
  end
  // state registers; reset discards any in-flight transaction
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      unit_q   <= 4'd0;
      last_q   <= 1'b1;
      win_q    <= 1'b0;
      result_q <= 1'b0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      unit_q   <= unit_d;
      last_q   <= last_d;
      win_q    <= win_d;
      result_q <= result_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
    end
  end
  assign {bus.unit_a, bus.unit_b, bus.unit_chave1, bus.unit_chave2} = unit_q;
  assign bus.gnt0   = gnt0_q;
  assign bus.gnt1   = gnt1_q;
  assign bus.done0  = done0_q;
  assign bus.done1  = done1_q;
  assign bus.result = result_q;
  assign bus.busy   = state_q != IDLE;
endmodule

// File: tb/tb_logic_unit_scheduler.sv
// tb_logic_unit_scheduler: directed vectors against a fast (settle 1) and a slow (settle 3) scheduler
module tb_logic_unit_scheduler;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  logic_unit_if bus1 ();
  logic_unit_if bus3 ();
  logic_unit_scheduler #(.SETTLE_CYCLES(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  logic_unit_scheduler #(.SETTLE_CYCLES(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));
  always #5 clk = ~clk;
  function automatic logic lu(input logic a, input logic b, input logic c1, input logic c2);
    logic r;
    r = c1 ? (a | b) : (a & b);
    return c2 ? ~r : r;
  endfunction
  assign bus1.unit_y = lu(bus1.unit_a, bus1.unit_b, bus1.unit_chave1, bus1.unit_chave2);
  assign bus3.unit_y = lu(bus3.unit_a, bus3.unit_b, bus3.unit_chave1, bus3.unit_chave2);
  typedef struct {
    logic       a;
    logic       b;
    logic [1:0] op;
    logic       exp;
  } vec_t;
  vec_t vecs [10];
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask
  function automatic logic [9:0] outs1();
    return {bus1.gnt0, bus1.gnt1, bus1.done0, bus1.done1, bus1.result, bus1.busy,
            bus1.unit_a, bus1.unit_b, bus1.unit_chave1, bus1.unit_chave2};
  endfunction
  function automatic logic [3:0] unit3();
    return {bus3.unit_a, bus3.unit_b, bus3.unit_chave1, bus3.unit_chave2};
  endfunction
  function automatic logic [3:0] unit1();
    return {bus1.unit_a, bus1.unit_b, bus1.unit_chave1, bus1.unit_chave2};
  endfunction
  initial begin
    vecs[0] = '{1'b1, 1'b0, 2'b00, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 2'b01, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 2'b10, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 2'b11, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 2'b00, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 2'b01, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 2'b10, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 2'b11, 1'b1};
    vecs[8] = '{1'b1, 1'b1, 2'b11, 1'b0};
    vecs[9] = '{1'b0, 1'b0, 2'b10, 1'b0};
    {bus1.req0, bus1.a0, bus1.b0, bus1.op0, bus1.req1, bus1.a1, bus1.b1, bus1.op1} = '0;
    {bus3.req0, bus3.a0, bus3.b0, bus3.op0, bus3.req1, bus3.a1, bus3.b1, bus3.op1} = '0;
    step();
    step();
    chk("reset_outs1", 16'(outs1()), 16'h0);
    chk("reset_busy3", 16'(bus3.busy), 16'h0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus1.req0 = 1'b1;
      {bus1.a0, bus1.b0, bus1.op0} = {vecs[i].a, vecs[i].b, vecs[i].op};
      step();
      chk($sformatf("t1_gnt_%0d", i), 16'({bus1.gnt0, bus1.gnt1, bus1.busy}), 16'b101);
      chk($sformatf("t1_unit_%0d", i), 16'(unit1()), 16'({vecs[i].a, vecs[i].b, vecs[i].op}));
      bus1.req0 = 1'b0;
      step();
      chk($sformatf("t1_mid_%0d", i), 16'({bus1.gnt0, bus1.done0, bus1.busy}), 16'b001);
      step();
      chk($sformatf("t1_done_%0d", i), 16'({bus1.done0, bus1.done1, bus1.busy}), 16'b100);
      chk($sformatf("t1_res_%0d", i), 16'(bus1.result), 16'(vecs[i].exp));
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    {bus1.req0, bus1.a0, bus1.b0, bus1.op0} = {1'b1, 1'b1, 1'b1, 2'b00};
    {bus1.req1, bus1.a1, bus1.b1, bus1.op1} = {1'b1, 1'b0, 1'b0, 2'b11};
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("t2_gnt_%0d", k), 16'({bus1.gnt0, bus1.gnt1}), k == 1 ? 16'b01 : 16'b10);
      step();
      chk($sformatf("t2_quiet_%0d", k), 16'({bus1.gnt0, bus1.gnt1, bus1.done0, bus1.done1}), 16'b0);
      step();
      chk($sformatf("t2_done_%0d", k), 16'({bus1.done0, bus1.done1}), k == 1 ? 16'b01 : 16'b10);
      chk($sformatf("t2_res_%0d", k), 16'(bus1.result), 16'b1);
    end
    bus1.req0 = 1'b0;
    bus1.req1 = 1'b0;
    step();
    {bus3.req1, bus3.a1, bus3.b1, bus3.op1} = {1'b1, 1'b1, 1'b1, 2'b10};
    step();
    chk("t3_gnt", 16'({bus3.gnt0, bus3.gnt1, bus3.busy}), 16'b011);
    chk("t3_unit0", 16'(unit3()), 16'b1110);
    {bus3.req1, bus3.a1, bus3.b1, bus3.op1} = {1'b0, 1'b0, 1'b0, 2'b01};
    for (int i = 1; i <= 3; i++) begin
      step();
      chk($sformatf("t3_hold_%0d", i), 16'({unit3(), bus3.gnt1, bus3.done1, bus3.busy}), 16'b1110_001);
    end
    step();
    chk("t3_done", 16'({bus3.done1, bus3.done0, bus3.busy}), 16'b100);
    chk("t3_res", 16'(bus3.result), 16'b1);
    {bus1.req0, bus1.a0, bus1.b0, bus1.op0} = {1'b1, 1'b0, 1'b1, 2'b00};
    step();
    chk("t4_gnt0", 16'({bus1.gnt0, bus1.gnt1}), 16'b10);
    {bus1.req0, bus1.a0, bus1.op0} = {1'b0, 1'b1, 2'b10};
    {bus1.req1, bus1.a1, bus1.b1, bus1.op1} = {1'b1, 1'b1, 1'b0, 2'b10};
    step();
    chk("t4_stable", 16'({unit1(), bus1.gnt1}), 16'b0100_0);
    step();
    chk("t4_done0", 16'({bus1.done0, bus1.result, bus1.gnt1}), 16'b100);
    step();
    chk("t4_gnt1", 16'({bus1.gnt1, unit1()}), 16'b1_1010);
    bus1.req1 = 1'b0;
    step();
    step();
    chk("t4_done1", 16'({bus1.done1, bus1.result}), 16'b11);
    {bus1.req0, bus1.a0, bus1.b0, bus1.op0} = {1'b1, 1'b1, 1'b1, 2'b00};
    step();
    chk("t5_gnt0", 16'(bus1.gnt0), 16'b1);
    bus1.req0 = 1'b0;
    reset = 1'b1;
    step();
    chk("t5_reset_outs", 16'(outs1()), 16'h0);
    reset = 1'b0;
    step();
    chk("t5_no_done", 16'({bus1.done0, bus1.done1, bus1.busy}), 16'b0);
    bus1.req0 = 1'b1;
    bus1.req1 = 1'b1;
    step();
    chk("t5_first_gnt", 16'({bus1.gnt0, bus1.gnt1}), 16'b10);
    bus1.req0 = 1'b0;
    bus1.req1 = 1'b0;
    step();
    step();
    chk("t5_done0", 16'({bus1.done0, bus1.done1, bus1.result}), 16'b101);
    {bus3.req1, bus3.a1, bus3.b1, bus3.op1} = {1'b1, 1'b0, 1'b0, 2'b01};
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("t6_gnt_%0d", k), 16'({bus3.gnt1, bus3.busy}), 16'b11);
      for (int i = 0; i < 3; i++) begin
        step();
        chk($sformatf("t6_wait_%0d_%0d", k, i), 16'({bus3.gnt1, bus3.done1}), 16'b00);
      end
      step();
      chk($sformatf("t6_done_%0d", k), 16'({bus3.done1, bus3.gnt1, bus3.busy, bus3.result}), 16'b1001);
    end
    bus3.req1 = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
